// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types for the core-side memory port arbiter: transaction owner,
//   arbiter FSM state, requester bit indices and a one-hot to owner helper.
//   State encodings are kept as explicit localparams so that the values seen
//   in legacy waveforms and debug tooling stay the same.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Requester indices inside the {ST, LD, IFU} request / winner vectors
    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned IDX_IFU = 0;
    localparam int unsigned IDX_LD  = 1;
    localparam int unsigned IDX_ST  = 2;

    // Legacy FSM encodings
    localparam logic [1:0] ARB_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ARB_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ARB_WAIT_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = ARB_IDLE_ENC,
        ARB_ISSUE = ARB_ISSUE_ENC,
        ARB_WAIT  = ARB_WAIT_ENC
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        ARB_OWN_IFU = 2'd0,
        ARB_OWN_LD  = 2'd1,
        ARB_OWN_ST  = 2'd2
    } mem_arb_owner_t;

    // Winner vector is one-hot (or zero when nothing is eligible)
    function automatic mem_arb_owner_t onehot_to_owner(input logic [NUM_REQ-1:0] win);
        mem_arb_owner_t own;
        own = ARB_OWN_IFU;
        if (win[IDX_ST]) begin
            own = ARB_OWN_ST;
        end else if (win[IDX_LD]) begin
            own = ARB_OWN_LD;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
//   Combinational priority picker for the memory port arbiter.
//   Order: urgent store, then starving requesters (IFU, LD, ST),
//   then the normal order LD > IFU > ST.
// Ports
//   req       in  [2:0]  eligible requests {ST, LD, IFU}
//   urgent    in  1      store buffer nearly full
//   starving  in  [2:0]  wait counter at its limit {ST, LD, IFU}
//   win       out [2:0]  one-hot winner, zero when no request
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               urgent,
    input  logic [NUM_REQ-1:0] starving,
    output logic [NUM_REQ-1:0] win
);

    logic [NUM_REQ-1:0] starve_req;

    assign starve_req = req & starving;

    always_comb begin
        win = '0;
        if (urgent && req[IDX_ST]) begin
            win[IDX_ST] = 1'b1;
        end else if (starve_req[IDX_IFU]) begin
            win[IDX_IFU] = 1'b1;
        end else if (starve_req[IDX_LD]) begin
            win[IDX_LD] = 1'b1;
        end else if (starve_req[IDX_ST]) begin
            win[IDX_ST] = 1'b1;
        end else if (req[IDX_LD]) begin
            win[IDX_LD] = 1'b1;
        end else if (req[IDX_IFU]) begin
            win[IDX_IFU] = 1'b1;
        end else if (req[IDX_ST]) begin
            win[IDX_ST] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single core-side memory port between instruction fetch (IFU),
//   data loads (LD) and committed-store drain (ST). One transaction is kept
//   outstanding: IDLE selects and latches a winner, ISSUE holds mem_req until
//   mem_ready, WAIT forwards the single-cycle response to the owner.
//   Arbitration: urgent store, then starving requesters, then LD > IFU > ST.
//
// Optional build macro
//   MEM_ARB_PERF_EN : adds 32-bit wrapping performance counters
//                     perf_ifu_cnt / perf_ld_cnt / perf_st_cnt (grants) and
//                     perf_stall_cnt (cycles with a request pending while busy).
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush                           kills IFU request / in-flight IFU response
//   ifu_req/addr -> ifu_gnt/rvalid/rdata   fetch port
//   ld_req/addr  -> ld_gnt/rvalid/rdata    load port
//   st_req/addr/wdata/be/urgent -> st_gnt/st_done   store drain port
//   mem_req/we/addr/wdata/be, mem_ready, mem_rvalid/rdata   memory side
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    // instruction fetch
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_gnt,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    // loads
    input  logic                ld_req,
    input  logic [ADDR_W-1:0]   ld_addr,
    output logic                ld_gnt,
    output logic                ld_rvalid,
    output logic [DATA_W-1:0]   ld_rdata,
    // store drain
    input  logic                st_req,
    input  logic [ADDR_W-1:0]   st_addr,
    input  logic [DATA_W-1:0]   st_wdata,
    input  logic [DATA_W/8-1:0] st_be,
    input  logic                st_urgent,
    output logic                st_gnt,
    output logic                st_done,
    // memory interface
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_ifu_cnt,
    output logic [31:0]         perf_ld_cnt,
    output logic [31:0]         perf_st_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    mem_arb_state_t      state_q, state_d;
    mem_arb_owner_t      owner_q;
    logic                killed_q;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W/8-1:0] lat_be;
    logic [CNT_W-1:0]    wait_cnt [NUM_REQ];

    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  starving;
    logic [NUM_REQ-1:0]  win;
    logic                select;
    logic                accept;
    logic                resp;
    logic                ifu_dead;
    logic [ADDR_W-1:0]   sel_addr;

    // A flushed fetch is simply not a candidate this cycle
    assign elig[IDX_IFU] = ifu_req && !flush;
    assign elig[IDX_LD]  = ld_req;
    assign elig[IDX_ST]  = st_req;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            starving[i] = (wait_cnt[i] == CNT_MAX);
        end
    end

    mem_arb_pick u_pick (
        .req      (elig),
        .urgent   (st_urgent),
        .starving (starving),
        .win      (win)
    );

    assign select = (state_q == ARB_IDLE) && (|elig);
    assign accept = (state_q == ARB_ISSUE) && mem_ready;
    assign resp   = (state_q == ARB_WAIT) && mem_rvalid;

    // Flush in the same cycle as the gnt/response must already suppress it,
    // so the registered kill flag is combined with the live flush.
    assign ifu_dead = killed_q || flush;

    always_comb begin
        sel_addr = ifu_addr;
        if (win[IDX_ST]) begin
            sel_addr = st_addr;
        end else if (win[IDX_LD]) begin
            sel_addr = ld_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE:  if (|elig)      state_d = ARB_ISSUE;
            ARB_ISSUE: if (mem_ready)  state_d = ARB_WAIT;
            ARB_WAIT:  if (mem_rvalid) state_d = ARB_IDLE;
            default:                   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= ARB_OWN_IFU;
            killed_q  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            state_q <= state_d;
            if (select) begin
                owner_q   <= onehot_to_owner(win);
                lat_we    <= win[IDX_ST];
                lat_addr  <= sel_addr;
                lat_wdata <= win[IDX_ST] ? st_wdata : '0;
                lat_be    <= win[IDX_ST] ? st_be : '0;
            end
            if (state_q == ARB_IDLE) begin
                killed_q <= 1'b0;
            end else if (flush && owner_q == ARB_OWN_IFU) begin
                killed_q <= 1'b1;
            end
        end
    end

    // Losers that were eligible age by one per arbitration; the winner restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_cnt[i] <= '0;
            end
        end else if (select) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (win[i]) begin
                    wait_cnt[i] <= '0;
                end else if (elig[i] && !starving[i]) begin
                    wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign mem_req   = (state_q == ARB_ISSUE);
    assign mem_we    = mem_req && lat_we;
    assign mem_addr  = mem_req ? lat_addr  : '0;
    assign mem_wdata = mem_req ? lat_wdata : '0;
    assign mem_be    = mem_req ? lat_be    : '0;

    assign ifu_gnt    = accept && (owner_q == ARB_OWN_IFU) && !ifu_dead;
    assign ld_gnt     = accept && (owner_q == ARB_OWN_LD);
    assign st_gnt     = accept && (owner_q == ARB_OWN_ST);

    assign ifu_rvalid = resp && (owner_q == ARB_OWN_IFU) && !ifu_dead;
    assign ld_rvalid  = resp && (owner_q == ARB_OWN_LD);
    assign st_done    = resp && (owner_q == ARB_OWN_ST);

    assign ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
    assign ld_rdata   = ld_rvalid  ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ifu_cnt   <= '0;
            perf_ld_cnt    <= '0;
            perf_st_cnt    <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (ifu_gnt) perf_ifu_cnt <= perf_ifu_cnt + 32'd1;
            if (ld_gnt)  perf_ld_cnt  <= perf_ld_cnt + 32'd1;
            if (st_gnt)  perf_st_cnt  <= perf_st_cnt + 32'd1;
            if ((ifu_req || ld_req || st_req) && state_q != ARB_IDLE) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: a cycle table for single-transaction
//   behaviour, flush and idle-response cases, plus hand sequences for the
//   arbitration order, starvation promotion and reset during WAIT.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [31:0] IFU_A = 32'h0000_0040;
    localparam logic [31:0] LD_A  = 32'h0000_0100;
    localparam logic [31:0] ST_A  = 32'h0000_0200;
    localparam logic [31:0] ST_D  = 32'h1234_5678;
    localparam logic [3:0]  ST_BE = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ifu_req = 1'b0, ld_req = 1'b0, st_req = 1'b0, st_urgent = 1'b0;
    logic [31:0] ifu_addr = IFU_A, ld_addr = LD_A, st_addr = ST_A, st_wdata = ST_D;
    logic [3:0]  st_be = ST_BE;
    logic        ifu_gnt, ifu_rvalid, ld_gnt, ld_rvalid, st_gnt, st_done;
    logic [31:0] ifu_rdata, ld_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_ifu_cnt, perf_ld_cnt, perf_st_cnt, perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_WAIT(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata), .st_be(st_be),
        .st_urgent(st_urgent), .st_gnt(st_gnt), .st_done(st_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_ifu_cnt(perf_ifu_cnt), .perf_ld_cnt(perf_ld_cnt),
        .perf_st_cnt(perf_st_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    int gnt_log[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at posedge+1; leaves at posedge+1 with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0; ifu_req = 1'b0; ld_req = 1'b0; st_req = 1'b0; st_urgent = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [127:0] pack_outs();
        return {mem_req,
                mem_req ? mem_we : 1'b0,
                mem_req ? mem_addr : 32'h0,
                (mem_req && mem_we) ? mem_be : 4'h0,
                (mem_req && mem_we) ? mem_wdata : 32'h0,
                st_gnt, ld_gnt, ifu_gnt,
                st_done, ld_rvalid, ifu_rvalid,
                ld_rvalid ? ld_rdata : (ifu_rvalid ? ifu_rdata : 32'h0)};
    endfunction

    typedef struct {
        bit          rst;
        bit          ir, lr, sr, su, fl, rdy, rv;
        logic [31:0] rdata;
        bit          e_req, e_we;
        logic [31:0] e_addr;
        logic [2:0]  e_gnt;   // {st, ld, ifu}
        logic [2:0]  e_rv;    // {st_done, ld_rvalid, ifu_rvalid}
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[31];

    // Drives ld/ifu/st requests with mem_ready=1 and a response one cycle after
    // each grant; records the order of grants (0=IFU, 1=LD, 2=ST).
    task automatic serve(input int n, input bit keep_all);
        bit resp_next = 1'b0;
        bit drop_i, drop_l, drop_s;
        gnt_log.delete();
        mem_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && gnt_log.size() < n; cyc++) begin
            mem_rvalid = resp_next;
            resp_next = 1'b0;
            drop_i = 1'b0; drop_l = 1'b0; drop_s = 1'b0;
            #4;
            if (ifu_gnt) begin gnt_log.push_back(0); resp_next = 1'b1; drop_i = !keep_all; end
            if (ld_gnt)  begin gnt_log.push_back(1); resp_next = 1'b1; drop_l = !keep_all; end
            if (st_gnt)  begin gnt_log.push_back(2); resp_next = 1'b1; drop_s = !keep_all; end
            @(posedge clk); #1;
            if (drop_i) ifu_req = 1'b0;
            if (drop_l) ld_req = 1'b0;
            if (drop_s) st_req = 1'b0;
        end
        ifu_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        mem_ready = 1'b0;
        mem_rvalid = resp_next;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
    endtask

    task automatic check_order(input string name, input int exp[]);
        check({name, "_count"}, 128'(gnt_log.size()), 128'(exp.size()));
        for (int i = 0; i < exp.size() && i < gnt_log.size(); i++) begin
            check($sformatf("%s_gnt%0d", name, i), 128'(gnt_log[i]), 128'(exp[i]));
        end
    endtask

    initial begin
        logic [127:0] exp;
        int ord2[]  = '{1, 0, 2};
        int ord4[]  = '{1, 1, 1, 1, 0, 2, 1, 1, 1, 0, 2};
        int ord4b[] = '{1, 1, 1, 1, 2};

        //          rst ir lr sr su fl rdy rv rdata          req we addr   gnt   rv     rdata
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        // single load, response two cycles after grant
        vecs[1]  = '{0, 0, 1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[2]  = '{0, 0, 1, 0, 0, 0, 1, 0, 32'h0,          1, 0, LD_A,  3'b010, 3'b000, 32'h0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,   0, 0, 32'h0, 3'b000, 3'b010, 32'hDEADBEEF};
        // stray response while idle
        vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111,   0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        // urgent store beats load; mem_req held while not ready
        vecs[6]  = '{0, 0, 1, 1, 1, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[7]  = '{0, 0, 1, 1, 1, 0, 0, 0, 32'h0,          1, 1, ST_A,  3'b000, 3'b000, 32'h0};
        vecs[8]  = '{0, 0, 1, 1, 1, 0, 1, 0, 32'h0,          1, 1, ST_A,  3'b100, 3'b000, 32'h0};
        vecs[9]  = '{0, 0, 1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[10] = '{0, 0, 1, 0, 0, 0, 0, 1, 32'h0,          0, 0, 32'h0, 3'b000, 3'b100, 32'h0};
        vecs[11] = '{0, 0, 1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[12] = '{0, 0, 1, 0, 0, 0, 1, 0, 32'h0,          1, 0, LD_A,  3'b010, 3'b000, 32'h0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h00000005,   0, 0, 32'h0, 3'b000, 3'b010, 32'h00000005};
        // flush in IDLE: fetch not selected
        vecs[14] = '{0, 1, 0, 0, 0, 1, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        // flush in WAIT with IFU owner, pending load then served
        vecs[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[17] = '{0, 1, 0, 0, 0, 0, 1, 0, 32'h0,          1, 0, IFU_A, 3'b001, 3'b000, 32'h0};
        vecs[18] = '{0, 0, 1, 0, 0, 1, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[19] = '{0, 0, 1, 0, 0, 0, 0, 1, 32'h0000CAFE,   0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[20] = '{0, 0, 1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[21] = '{0, 0, 1, 0, 0, 0, 1, 0, 32'h0,          1, 0, LD_A,  3'b010, 3'b000, 32'h0};
        vecs[22] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h00000077,   0, 0, 32'h0, 3'b000, 3'b010, 32'h00000077};
        // flush in ISSUE: memory still accepts, gnt and response hidden
        vecs[23] = '{0, 1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[24] = '{0, 1, 0, 0, 0, 1, 0, 0, 32'h0,          1, 0, IFU_A, 3'b000, 3'b000, 32'h0};
        vecs[25] = '{0, 1, 0, 0, 0, 0, 1, 0, 32'h0,          1, 0, IFU_A, 3'b000, 3'b000, 32'h0};
        vecs[26] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[27] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h00000099,   0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        // kill flag gone: a fresh fetch completes normally
        vecs[28] = '{0, 1, 0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 32'h0, 3'b000, 3'b000, 32'h0};
        vecs[29] = '{0, 1, 0, 0, 0, 0, 1, 0, 32'h0,          1, 0, IFU_A, 3'b001, 3'b000, 32'h0};
        vecs[30] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h0000600D,   0, 0, 32'h0, 3'b000, 3'b001, 32'h0000600D};

        #1;
        do_reset();

        for (int i = 0; i < 31; i++) begin
            if (vecs[i].rst) do_reset();
            ifu_req = vecs[i].ir; ld_req = vecs[i].lr; st_req = vecs[i].sr;
            st_urgent = vecs[i].su; flush = vecs[i].fl;
            mem_ready = vecs[i].rdy; mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rdata;
            #4;
            exp = {vecs[i].e_req, vecs[i].e_we, vecs[i].e_addr,
                   vecs[i].e_we ? ST_BE : 4'h0, vecs[i].e_we ? ST_D : 32'h0,
                   vecs[i].e_gnt, vecs[i].e_rv, vecs[i].e_rdata};
            check($sformatf("vec%0d", i), pack_outs(), exp);
            @(posedge clk); #1;
        end

        // fixed priority with three simultaneous one-shot requests
        do_reset();
        ifu_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
        serve(3, 1'b0);
        check_order("order", ord2);

        // starvation with all three requesters permanently asserted
        do_reset();
        ifu_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
        serve(11, 1'b1);
        check_order("starve3", ord4);

        // load and store only: store loses four, wins the fifth
        do_reset();
        ld_req = 1'b1; st_req = 1'b1;
        serve(5, 1'b1);
        check_order("starve2", ord4b);

        // reset asserted during WAIT
        do_reset();
        ld_req = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b1;
        #4 check("rst_pre_gnt", 128'({mem_req, ld_gnt}), 128'(2'b11));
        @(posedge clk); #1;
        ld_req = 1'b0; mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #2 rst_n = 1'b0;
        #1 check("rst_outs_zero", pack_outs(), 128'h0);
        check("rst_data_zero", {32'h0, mem_addr, mem_wdata, ld_rdata | ifu_rdata},
              128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #4 check("rst_late_rvalid", 128'({ld_rvalid, ifu_rvalid, st_done, mem_req}), 128'h0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0; ld_req = 1'b1;
        #4 check("rst_new_idle", 128'({mem_req, ld_gnt}), 128'h0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        #4 check("rst_new_gnt", 128'({mem_req, ld_gnt, mem_addr}), {94'h0, 2'b11, LD_A});
        @(posedge clk); #1;
        ld_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        #4 check("rst_new_rvalid", 128'({ld_rvalid, ld_rdata}), {95'h0, 1'b1, 32'h0BADF00D});
        @(posedge clk); #1;
        mem_rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
